// File: rtl/systolic_array_driver_if.sv
// ---------------------------------------------------------------------------
// systolic_array_driver_if
//
// Groups every non-clock signal of the systolic array front-end into one
// bundle: the operand byte stream, the array operand/result ports and the
// result word stream.
//
// Signals:
//   s_valid / s_ready / s_data[7:0]   operand byte stream (a11..a22, b11..b22)
//   arr_rst                           active-high reset to the array
//   arr_a[31:0] / arr_b[31:0]         operands {x22,x21,x12,x11}
//   arr_c[67:0]                       array results {c22,c21,c12,c11}
//   m_valid / m_ready / m_data[16:0]  result word stream (c11,c12,c21,c22)
//   m_last                            marks c22
//   busy                              high while clearing, running or sending
//
// Modports:
//   master  the driver itself
//   slave   whatever feeds it bytes, models the array and drains results
// ---------------------------------------------------------------------------
interface systolic_array_driver_if;

    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        arr_rst;
    logic [31:0] arr_a;
    logic [31:0] arr_b;
    logic [67:0] arr_c;
    logic        m_valid;
    logic        m_ready;
    logic [16:0] m_data;
    logic        m_last;
    logic        busy;

    modport master (
        input  s_valid, s_data, arr_c, m_ready,
        output s_ready, arr_rst, arr_a, arr_b, m_valid, m_data, m_last, busy
    );

    modport slave (
        output s_valid, s_data, arr_c, m_ready,
        input  s_ready, arr_rst, arr_a, arr_b, m_valid, m_data, m_last, busy
    );

endinterface

// File: rtl/systolic_array_driver.sv
// ---------------------------------------------------------------------------
// systolic_array_driver
//
// Front-end controller for the 2x2 systolic matrix multiplier. Collects the
// eight operand bytes from a valid/ready byte stream, holds them on the
// array's operand ports, pulses the array reset, waits LATENCY cycles, then
// captures the four 17-bit results and returns them as a valid/ready word
// stream.
//
// Parameters:
//   LATENCY   cycles the array needs with arr_rst low before its outputs are
//             valid (1..15)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous, active-low reset
//   bus       systolic_array_driver_if.master (byte stream, array ports,
//             result stream, busy)
//
// Build option:
//   SYSTOLIC_DRV_SAT16_EN  when defined, each captured result above 65535 is
//                          stored as 65535; otherwise results pass unchanged.
// ---------------------------------------------------------------------------
module systolic_array_driver #(
    parameter int LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    systolic_array_driver_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        RUN,
        SEND
    } state_t;

    localparam logic [3:0] LastCount = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic        started_q;
    logic [2:0]  byteIdx_q, byteIdx_d;
    logic [1:0]  wordIdx_q, wordIdx_d;
    logic [3:0]  runCnt_q, runCnt_d;
    logic [7:0]  operand_q [8];
    logic [16:0] result_q  [4];
    logic        byteAccept;
    logic        wordTaken;
    logic        captureEn;

    // Applies the optional 16-bit clamp to one raw array result.
    function automatic logic [16:0] captureWord(input logic [16:0] raw);
`ifdef SYSTOLIC_DRV_SAT16_EN
        return raw[16] ? 17'd65535 : raw;
`else
        return raw;
`endif
    endfunction

    // Next-state logic. Byte and word indices are 3-bit and 2-bit so they
    // wrap back to zero by themselves after the last byte or word.
    // IDLE waits for started_q, which gives the first clock edge after reset
    // release to settling, so s_ready first rises on the second edge.
    always_comb begin
        state_d    = state_q;
        byteIdx_d  = byteIdx_q;
        wordIdx_d  = wordIdx_q;
        runCnt_d   = runCnt_q;
        byteAccept = 1'b0;
        wordTaken  = 1'b0;
        captureEn  = 1'b0;

        case (state_q)
            IDLE: begin
                if (started_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                byteAccept = bus.s_valid;
                if (bus.s_valid) begin
                    byteIdx_d = byteIdx_q + 3'd1;
                    if (byteIdx_q == 3'd7) begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                runCnt_d = 4'd0;
                state_d  = RUN;
            end
            RUN: begin
                if (runCnt_q == LastCount) begin
                    captureEn = 1'b1;
                    runCnt_d  = 4'd0;
                    state_d   = SEND;
                end else begin
                    runCnt_d = runCnt_q + 4'd1;
                end
            end
            SEND: begin
                wordTaken = bus.m_ready;
                if (bus.m_ready) begin
                    wordIdx_d = wordIdx_q + 2'd1;
                    if (wordIdx_q == 2'd3) begin
                        state_d = LOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register plus the indices and the latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
            byteIdx_q <= 3'd0;
            wordIdx_q <= 2'd0;
            runCnt_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            byteIdx_q <= byteIdx_d;
            wordIdx_q <= wordIdx_d;
            runCnt_q  <= runCnt_d;
        end
    end

    // Operand bytes are written only on an accepted byte, so the array sees
    // stable operands through CLEAR and RUN. A reset mid-load zeroes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                operand_q[i] <= 8'd0;
            end
        end else if (byteAccept) begin
            operand_q[byteIdx_q] <= bus.s_data;
        end
    end

    // Results are sampled from the array only on the last RUN edge; the
    // array output is ignored at every other time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                result_q[i] <= 17'd0;
            end
        end else if (captureEn) begin
            for (int i = 0; i < 4; i++) begin
                result_q[i] <= captureWord(bus.arr_c[17*i +: 17]);
            end
        end
    end

    // Outputs decode directly from registered state, so m_data and m_last
    // cannot change while a word is stalled. arr_rst is released only in RUN.
    assign bus.s_ready = (state_q == LOAD);
    assign bus.arr_rst = (state_q != RUN);
    assign bus.arr_a   = {operand_q[3], operand_q[2], operand_q[1], operand_q[0]};
    assign bus.arr_b   = {operand_q[7], operand_q[6], operand_q[5], operand_q[4]};
    assign bus.m_valid = (state_q == SEND);
    assign bus.m_data  = result_q[wordIdx_q];
    assign bus.m_last  = (state_q == SEND) && (wordIdx_q == 2'd3);
    assign bus.busy    = (state_q == CLEAR) || (state_q == RUN) || (state_q == SEND);

    // wordTaken documents the SEND handshake; it feeds no register directly
    // because the word index update already lives in wordIdx_d.
    logic unusedWordTaken;
    assign unusedWordTaken = wordTaken;

endmodule

// File: tb/tb_systolic_array_driver.sv
// ---------------------------------------------------------------------------
// tb_systolic_array_driver
//
// Drives operand products into systolic_array_driver, models the 2x2 array
// behaviourally and checks the returned words, their timing and the
// handshake behaviour around stalls, gaps, reset and back-to-back products.
// ---------------------------------------------------------------------------
module tb_systolic_array_driver;

    localparam int LATENCY = 4;
    localparam int Half    = 5;

    typedef struct packed {
        logic [63:0] ops;
        logic [67:0] exp;
        logic [3:0]  gap;
        logic [1:0]  mode;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int errors = 0;
    int cycles = 0;
    int phase  = 0;
    int firstAcceptCycle = 0;
    int lastAcceptCycle  = 0;
    int riseCycle        = 0;
    int lastShakeCycle   = 0;
    int arrayRunCnt      = 0;

    systolic_array_driver_if bus ();

    systolic_array_driver #(.LATENCY(LATENCY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #Half clk = ~clk;

    always @(posedge clk) cycles <= cycles + 1;

    // True 2x2 matrix product from the byte list a11,a12,a21,a22,b11..b22.
    function automatic logic [67:0] matProduct(input logic [63:0] ops);
        int a11, a12, a21, a22, b11, b12, b21, b22;
        int c11, c12, c21, c22;
        a11 = int'(ops[7:0]);   a12 = int'(ops[15:8]);
        a21 = int'(ops[23:16]); a22 = int'(ops[31:24]);
        b11 = int'(ops[39:32]); b12 = int'(ops[47:40]);
        b21 = int'(ops[55:48]); b22 = int'(ops[63:56]);
        c11 = a11 * b11 + a12 * b21;
        c12 = a11 * b12 + a12 * b22;
        c21 = a21 * b11 + a22 * b21;
        c22 = a21 * b12 + a22 * b22;
        return {17'(c22), 17'(c21), 17'(c12), 17'(c11)};
    endfunction

    // Words the driver should return for a byte list, clamp included.
    function automatic logic [67:0] expectedWords(input logic [63:0] ops);
        logic [67:0] p;
        p = matProduct(ops);
`ifdef SYSTOLIC_DRV_SAT16_EN
        for (int i = 0; i < 4; i++) begin
            if (p[17*i +: 17] > 17'd65535) p[17*i +: 17] = 17'd65535;
        end
`endif
        return p;
    endfunction

    // Array model: all ones (an obviously wrong value) until arr_rst has been
    // low for LATENCY cycles, then the true product of its operand ports.
    always @(negedge clk) begin
        if (bus.arr_rst) begin
            arrayRunCnt <= 0;
            bus.arr_c   <= {68{1'b1}};
        end else begin
            arrayRunCnt <= arrayRunCnt + 1;
            bus.arr_c   <= (arrayRunCnt + 1 >= LATENCY) ? matProduct({bus.arr_b, bus.arr_a})
                                                        : {68{1'b1}};
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Just before each rising edge: a stalled word must still be presented
    // unchanged, and s_ready and busy must never be high together.
    initial begin
        logic        prevStall = 1'b0;
        logic [16:0] prevData  = 17'd0;
        logic        prevLast  = 1'b0;
        forever begin
            @(negedge clk);
            #(Half - 1);
            if (!rst_n) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall) begin
                    checkOutput("holdValid", 32'(bus.m_valid), 1);
                    checkOutput("holdData", 32'(bus.m_data), 32'(prevData));
                    checkOutput("holdLast", 32'(bus.m_last), 32'(prevLast));
                end
                checkOutput("readyBusy", 32'(bus.s_ready && bus.busy), 0);
                prevStall = bus.m_valid && !bus.m_ready;
                prevData  = bus.m_data;
                prevLast  = bus.m_last;
            end
        end
    end

    // Streams the eight bytes with 'gap' idle cycles before each one.
    task automatic applyStimulus(input logic [63:0] ops, input int gap);
        int budget;
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.s_valid = 1'b0;
                @(negedge clk);
                checkOutput("gapArrRst", 32'(bus.arr_rst), 1);
            end
            bus.s_valid = 1'b1;
            bus.s_data  = ops[8*i +: 8];
            budget = 0;
            while (!bus.s_ready && budget < 100) begin
                @(negedge clk);
                budget++;
            end
            checkOutput("acceptWait", 32'(bus.s_ready), 1);
            @(negedge clk);
            if (i == 0) firstAcceptCycle = cycles;
            lastAcceptCycle = cycles;
        end
        bus.s_valid = 1'b0;
        bus.s_data  = 8'd0;
    endtask

    // Drains 'count' words with the given m_ready pattern (0 always high,
    // 1 high one cycle in three, 2 random) and checks them against exp.
    task automatic collectWords(input logic [67:0] exp, input int mode, input int count);
        int budget;
        int w;
        checkOutput("clearArrRst", 32'(bus.arr_rst), 1);
        checkOutput("clearReady", 32'(bus.s_ready), 0);
        checkOutput("clearBusy", 32'(bus.busy), 1);
        @(negedge clk);
        checkOutput("runArrRst", 32'(bus.arr_rst), 0);
        budget = 0;
        while (!bus.m_valid && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("validWait", 32'(bus.m_valid), 1);
        riseCycle = cycles;
        checkOutput("validRise", 32'(riseCycle), 32'(lastAcceptCycle + 1 + LATENCY));
        w = 0;
        budget = 0;
        while (w < count && budget < 500) begin
            case (mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = ((phase % 3) == 0);
                default: bus.m_ready = 1'($urandom % 2);
            endcase
            phase++;
            checkOutput("validHeld", 32'(bus.m_valid), 1);
            if (bus.m_valid && bus.m_ready) begin
                checkOutput($sformatf("word%0d", w), 32'(bus.m_data), 32'(exp[17*w +: 17]));
                checkOutput($sformatf("last%0d", w), 32'(bus.m_last), 32'(w == 3));
                w++;
            end
            @(negedge clk);
            budget++;
        end
        checkOutput("wordCount", 32'(w), 32'(count));
        lastShakeCycle = cycles;
        if (count == 4) begin
            checkOutput("validDrop", 32'(bus.m_valid), 0);
            checkOutput("readyBack", 32'(bus.s_ready), 1);
            if (mode == 0) begin
                checkOutput("sendCycles", 32'(lastShakeCycle - riseCycle), 4);
            end
        end
        bus.m_ready = 1'b0;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("readyEdge1", 32'(bus.s_ready), 0);
        @(negedge clk);
        checkOutput("readyEdge2", 32'(bus.s_ready), 1);
        checkOutput("noWordAfterReset", 32'(bus.m_valid), 0);
    endtask

    initial begin
        vec_t        vecs [4];
        logic [63:0] basicOps;
        logic [63:0] identOps;
        logic [63:0] randOps;
        int          firstA;

        basicOps = {8'd3, 8'd18, 8'd19, 8'd13, 8'd2, 8'd6, 8'd7, 8'd131};
        identOps = {8'd8, 8'd7, 8'd6, 8'd5, 8'd1, 8'd0, 8'd0, 8'd1};

        vecs[0] = '{ops: basicOps, exp: {17'd120, 17'd114, 17'd2510, 17'd1829}, gap: 4'd0, mode: 2'd0};
        vecs[1] = '{ops: basicOps, exp: {17'd120, 17'd114, 17'd2510, 17'd1829}, gap: 4'd0, mode: 2'd1};
        vecs[2] = '{ops: basicOps, exp: {17'd120, 17'd114, 17'd2510, 17'd1829}, gap: 4'd3, mode: 2'd0};
`ifdef SYSTOLIC_DRV_SAT16_EN
        vecs[3] = '{ops: {8{8'd255}}, exp: {4{17'd65535}}, gap: 4'd0, mode: 2'd0};
`else
        vecs[3] = '{ops: {8{8'd255}}, exp: {4{17'd130050}}, gap: 4'd0, mode: 2'd0};
`endif

        bus.s_valid = 1'b0;
        bus.s_data  = 8'd0;
        bus.m_ready = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstReady", 32'(bus.s_ready), 0);
        checkOutput("rstArrRst", 32'(bus.arr_rst), 1);
        checkOutput("rstArrA", bus.arr_a, 0);
        checkOutput("rstArrB", bus.arr_b, 0);
        checkOutput("rstValid", 32'(bus.m_valid), 0);
        checkOutput("rstData", 32'(bus.m_data), 0);
        checkOutput("rstLast", 32'(bus.m_last), 0);
        checkOutput("rstBusy", 32'(bus.busy), 0);
        repeat (2) @(negedge clk);
        releaseReset();

        for (int i = 0; i < 4; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i].ops, int'(vecs[i].gap));
            collectWords(vecs[i].exp, int'(vecs[i].mode), 4);
        end

        $display("[TB] reset during SEND");
        applyStimulus(basicOps, 0);
        collectWords({17'd120, 17'd114, 17'd2510, 17'd1829}, 0, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstValid", 32'(bus.m_valid), 0);
        checkOutput("midRstArrRst", 32'(bus.arr_rst), 1);
        checkOutput("midRstBusy", 32'(bus.busy), 0);
        checkOutput("midRstArrA", bus.arr_a, 0);
        @(negedge clk);
        releaseReset();
        applyStimulus(identOps, 0);
        collectWords({17'd8, 17'd7, 17'd6, 17'd5}, 0, 4);

        $display("[TB] reset during LOAD");
        applyStimulus(basicOps, 0);
        collectWords({17'd120, 17'd114, 17'd2510, 17'd1829}, 0, 4);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'd99;
        repeat (3) @(negedge clk);
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("loadRstArrA", bus.arr_a, 0);
        @(negedge clk);
        releaseReset();
        applyStimulus(identOps, 0);
        collectWords({17'd8, 17'd7, 17'd6, 17'd5}, 0, 4);

        $display("[TB] back-to-back");
        applyStimulus(basicOps, 0);
        firstA = firstAcceptCycle;
        collectWords({17'd120, 17'd114, 17'd2510, 17'd1829}, 0, 4);
        randOps = {$urandom, $urandom};
        applyStimulus(randOps, 0);
        checkOutput("b2bFirstAccept", 32'(firstAcceptCycle), 32'(lastShakeCycle + 1));
        checkOutput("b2bThroughput", 32'(firstAcceptCycle - firstA), 32'(8 + 1 + LATENCY + 4));
        collectWords(expectedWords(randOps), 0, 4);

        $display("[TB] random products");
        for (int i = 0; i < 8; i++) begin
            randOps = {$urandom, $urandom};
            applyStimulus(randOps, int'($urandom_range(0, 2)));
            collectWords(expectedWords(randOps), 2, 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycles);
        $fatal(1, "[TB] watchdog");
    end

endmodule
